mips_multicycle_ctrl: RTL and testbench

- Multi-cycle control unit for the MIPS R/I/J core; replaces the per-class combinational decoders with one sequenced controller.
- Latches the instruction word and steps IF→ID→EX→(MEM)→(WB).
- Emits the existing datapath selects (PC_s, w_r_s, imm_s, rt_imm_s, wr_data_s, ALU_OP) plus per-phase write strobes.
- Memory latency is parametrised.

---
 rtl/mips_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS R/I/J control unit: latches the instruction and sequences IF -> ID -> EX -> (MEM) -> (WB).
// Optional macro ILLEGAL_TRAP_EN: undefined encodings lock the controller in TRAP instead of executing as NOP.
module mips_multicycle_ctrl #(
   parameter int MEM_LAT  = 1,
   parameter int CNT_W    = 4,
   parameter int LINK_REG = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] Inst_in,
   input  logic        ZF,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [15:0] imm_offset,
   output logic [25:0] j_addr,
   output logic [1:0]  PC_s,
   output logic [1:0]  w_r_s,
   output logic [1:0]  wr_data_s,
   output logic        imm_s,
   output logic        rt_imm_s,
   output logic [2:0]  ALU_OP,
   output logic        IR_Write,
   output logic        PC_Write,
   output logic        Mem_Read,
   output logic        Mem_Write,
   output logic        Write_Reg,
   output logic        Illegal,
   output logic [2:0]  state_o
);

   typedef enum logic [2:0] {
      S_IF  = 3'b000,
      S_ID  = 3'b001,
      S_EX  = 3'b010,
      S_MEM = 3'b011,
`ifdef ILLEGAL_TRAP_EN
      S_WB  = 3'b100,
      S_TRAP = 3'b101
`else
      S_WB  = 3'b100
`endif
   } state_t;

   typedef enum logic [2:0] {C_NOP, C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL} cls_t;

   typedef struct packed {
      cls_t       cls;
      logic [2:0] alu_op;
      logic       imm_s;
      logic       rt_imm_s;
      logic [1:0] w_r_s;
      logic [1:0] wr_data_s;
      logic [1:0] pc_s;
   } dec_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

   // The controller only emits w_r_s=10; the datapath mux resolves that to LINK_REG.
   if (MEM_LAT < 1 || MEM_LAT > 15 || MEM_LAT > (1 << CNT_W)) begin : g_bad_mem_lat
      $error("MEM_LAT must be 1..15 and fit in CNT_W bits");
   end
   if (LINK_REG < 1 || LINK_REG > 31) begin : g_bad_link_reg
      $error("LINK_REG must be a writable register index 1..31");
   end

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      ir;
   dec_t             dec;
   logic             last, cnt_clr;
   logic             ir_wr, pc_wr, mem_rd, mem_wr, reg_wr;

   assign rs         = ir[25:21];
   assign rt         = ir[20:16];
   assign rd         = ir[15:11];
   assign imm_offset = ir[15:0];
   assign j_addr     = ir[25:0];
   assign state_o    = state;
   assign last       = (cnt == LAST_CNT);

   // NOTE: every signal driven from always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      dec           = '{cls: C_NOP, default: '0};
      unique case (ir[31:26])
         6'b000000: begin
            dec.cls = C_ALU;
            case (ir[5:0])
               6'b100000: dec.alu_op = 3'b100;
               6'b100010: dec.alu_op = 3'b101;
               6'b100100: dec.alu_op = 3'b000;
               6'b100101: dec.alu_op = 3'b001;
               6'b100110: dec.alu_op = 3'b010;
               6'b100111: dec.alu_op = 3'b011;
               6'b101010: dec.alu_op = 3'b110;
               default:   dec.cls    = C_NOP;
            endcase
         end
         6'b001000: dec = '{cls: C_ALU, alu_op: 3'b100, imm_s: 1'b1, rt_imm_s: 1'b1, w_r_s: 2'b01, default: '0};
         6'b001100: dec = '{cls: C_ALU, alu_op: 3'b000, rt_imm_s: 1'b1, w_r_s: 2'b01, default: '0};
         6'b001101: dec = '{cls: C_ALU, alu_op: 3'b001, rt_imm_s: 1'b1, w_r_s: 2'b01, default: '0};
         6'b001110: dec = '{cls: C_ALU, alu_op: 3'b010, rt_imm_s: 1'b1, w_r_s: 2'b01, default: '0};
         6'b001010: dec = '{cls: C_ALU, alu_op: 3'b110, imm_s: 1'b1, rt_imm_s: 1'b1, w_r_s: 2'b01, default: '0};
         6'b100011: dec = '{cls: C_LW, alu_op: 3'b100, imm_s: 1'b1, rt_imm_s: 1'b1,
                            w_r_s: 2'b01, wr_data_s: 2'b01, default: '0};
         6'b101011: dec = '{cls: C_SW, alu_op: 3'b100, imm_s: 1'b1, rt_imm_s: 1'b1, default: '0};
         6'b000100: dec = '{cls: C_BEQ, alu_op: 3'b101, pc_s: 2'b10, default: '0};
         6'b000101: dec = '{cls: C_BNE, alu_op: 3'b101, pc_s: 2'b10, default: '0};
         6'b000010: dec = '{cls: C_J, pc_s: 2'b11, default: '0};
         6'b000011: dec = '{cls: C_JAL, w_r_s: 2'b10, wr_data_s: 2'b10, pc_s: 2'b11, default: '0};
         default:   dec = '{cls: C_NOP, default: '0};
      endcase
   end

   always_comb begin
      state_nx  = state;
      ir_wr     = 1'b0;
      pc_wr     = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      reg_wr    = 1'b0;
      PC_s      = 2'b00;
      w_r_s     = 2'b00;
      wr_data_s = 2'b00;
      imm_s     = 1'b0;
      rt_imm_s  = 1'b0;
      ALU_OP    = 3'b000;
      // Selects decoded in EX stay up through MEM and WB so the datapath sees stable operands.
      if (state == S_EX || state == S_MEM || state == S_WB) begin
         PC_s      = dec.pc_s;
         w_r_s     = dec.w_r_s;
         wr_data_s = dec.wr_data_s;
         imm_s     = dec.imm_s;
         rt_imm_s  = dec.rt_imm_s;
         ALU_OP    = dec.alu_op;
      end
      case (state)
         S_IF: begin
            mem_rd = 1'b1;
            if (last) begin
               ir_wr    = 1'b1;
               pc_wr    = 1'b1;
               state_nx = S_ID;
            end
         end
         S_ID: state_nx = S_EX;
         S_EX: begin
            case (dec.cls)
               C_ALU, C_JAL: state_nx = S_WB;
               C_LW, C_SW:   state_nx = S_MEM;
               C_BEQ: begin pc_wr = ZF;  state_nx = S_IF; end
               C_BNE: begin pc_wr = !ZF; state_nx = S_IF; end
               C_J:   begin pc_wr = 1'b1; state_nx = S_IF; end
`ifdef ILLEGAL_TRAP_EN
               default: state_nx = S_TRAP;
`else
               default: state_nx = S_IF;
`endif
            endcase
         end
         S_MEM: begin
            mem_rd = (dec.cls == C_LW);
            if (last) begin
               mem_wr   = (dec.cls == C_SW);
               state_nx = (dec.cls == C_LW) ? S_WB : S_IF;
            end
         end
         S_WB: begin
            reg_wr   = 1'b1;
            pc_wr    = (dec.cls == C_JAL);
            state_nx = S_IF;
         end
`ifdef ILLEGAL_TRAP_EN
         S_TRAP: state_nx = S_TRAP;
`endif
         default: state_nx = S_IF;
      endcase
      cnt_clr = (state_nx != state) || !(state == S_IF || state == S_MEM);
   end

   // Strobes are suppressed while stalled or in reset so nothing fires from an abandoned instruction.
   assign IR_Write  = ir_wr  & en & ~rst;
   assign PC_Write  = pc_wr  & en & ~rst;
   assign Mem_Read  = mem_rd & en & ~rst;
   assign Mem_Write = mem_wr & en & ~rst;
   assign Write_Reg = reg_wr & en & ~rst;

`ifdef ILLEGAL_TRAP_EN
   assign Illegal = (state == S_TRAP);
`else
   assign Illegal = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IF;
         cnt   <= '0;
         ir    <= '0;
      end else if (en) begin
         state <= state_nx;
         cnt   <= cnt_clr ? '0 : cnt + 1'b1;
         if (ir_wr) ir <= Inst_in;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-instruction cycle traces are queued at issue and compared each cycle.
// Two instances (MEM_LAT=1 and MEM_LAT=3) share stimulus; the idle one is held in reset.
module tb_mips_multicycle_ctrl;

   localparam logic [2:0] ST_IF = 3'b000, ST_ID = 3'b001, ST_EX = 3'b010,
                          ST_MEM = 3'b011, ST_WB = 3'b100, ST_TRAP = 3'b101;
   // strobe order: IR_Write, PC_Write, Mem_Read, Mem_Write, Write_Reg
   localparam logic [4:0] S_IRW = 5'b10000, S_PCW = 5'b01000, S_MR = 5'b00100,
                          S_MW = 5'b00010, S_WR = 5'b00001;
   localparam logic [6:0] M_ILL = 7'b1000000, M_PCS = 7'b0100000, M_WRS = 7'b0010000,
                          M_WDS = 7'b0001000, M_ALU = 7'b0000100, M_IMM = 7'b0000010,
                          M_RTI = 7'b0000001;
   localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_JAL = 4, K_ILL = 5;

   typedef struct packed {
      logic [2:0] st;
      logic [4:0] strb;
      logic       ill;
      logic [1:0] pc_s;
      logic [1:0] w_r_s;
      logic [1:0] wr_data_s;
      logic [2:0] alu;
      logic       imm_s;
      logic       rt_imm_s;
      logic [6:0] mask;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst1, rst3, en, ZF, dsel;
   logic [31:0] Inst_in;
   int          n_vec = 0, n_err = 0;
   string       cur_tag = "init";
   exp_t        sb[$];
   exp_t        obs, mon_e;
   logic        mon_ok;

   logic [4:0]  d1_rs, d1_rt, d1_rd, d3_rs, d3_rt, d3_rd, f_rs, f_rt, f_rd;
   logic [15:0] d1_imm, d3_imm, f_imm;
   logic [25:0] d1_ja, d3_ja, f_ja;
   logic [1:0]  d1_pcs, d1_wrs, d1_wds, d3_pcs, d3_wrs, d3_wds;
   logic        d1_imms, d1_rti, d3_imms, d3_rti;
   logic [2:0]  d1_alu, d3_alu, d1_st, d3_st;
   logic        d1_irw, d1_pcw, d1_mr, d1_mw, d1_wr, d1_ill;
   logic        d3_irw, d3_pcw, d3_mr, d3_mw, d3_wr, d3_ill;

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.MEM_LAT(1), .CNT_W(4), .LINK_REG(31)) u_dut1 (
      .clk(clk), .rst(rst1), .en(en), .Inst_in(Inst_in), .ZF(ZF),
      .rs(d1_rs), .rt(d1_rt), .rd(d1_rd), .imm_offset(d1_imm), .j_addr(d1_ja),
      .PC_s(d1_pcs), .w_r_s(d1_wrs), .wr_data_s(d1_wds), .imm_s(d1_imms), .rt_imm_s(d1_rti),
      .ALU_OP(d1_alu), .IR_Write(d1_irw), .PC_Write(d1_pcw), .Mem_Read(d1_mr),
      .Mem_Write(d1_mw), .Write_Reg(d1_wr), .Illegal(d1_ill), .state_o(d1_st));

   mips_multicycle_ctrl #(.MEM_LAT(3), .CNT_W(4), .LINK_REG(31)) u_dut3 (
      .clk(clk), .rst(rst3), .en(en), .Inst_in(Inst_in), .ZF(ZF),
      .rs(d3_rs), .rt(d3_rt), .rd(d3_rd), .imm_offset(d3_imm), .j_addr(d3_ja),
      .PC_s(d3_pcs), .w_r_s(d3_wrs), .wr_data_s(d3_wds), .imm_s(d3_imms), .rt_imm_s(d3_rti),
      .ALU_OP(d3_alu), .IR_Write(d3_irw), .PC_Write(d3_pcw), .Mem_Read(d3_mr),
      .Mem_Write(d3_mw), .Write_Reg(d3_wr), .Illegal(d3_ill), .state_o(d3_st));

   assign obs = dsel ?
      {d3_st, d3_irw, d3_pcw, d3_mr, d3_mw, d3_wr, d3_ill, d3_pcs, d3_wrs, d3_wds, d3_alu, d3_imms, d3_rti, 7'b0} :
      {d1_st, d1_irw, d1_pcw, d1_mr, d1_mw, d1_wr, d1_ill, d1_pcs, d1_wrs, d1_wds, d1_alu, d1_imms, d1_rti, 7'b0};
   assign f_rs  = dsel ? d3_rs  : d1_rs;
   assign f_rt  = dsel ? d3_rt  : d1_rt;
   assign f_rd  = dsel ? d3_rd  : d1_rd;
   assign f_imm = dsel ? d3_imm : d1_imm;
   assign f_ja  = dsel ? d3_ja  : d1_ja;

   // Scoreboard consumer: one queued expectation per clock, sampled mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e  = sb.pop_front();
         mon_ok = (obs.st === mon_e.st) && (obs.strb === mon_e.strb)
               && (!mon_e.mask[6] || obs.ill       === mon_e.ill)
               && (!mon_e.mask[5] || obs.pc_s      === mon_e.pc_s)
               && (!mon_e.mask[4] || obs.w_r_s     === mon_e.w_r_s)
               && (!mon_e.mask[3] || obs.wr_data_s === mon_e.wr_data_s)
               && (!mon_e.mask[2] || obs.alu       === mon_e.alu)
               && (!mon_e.mask[1] || obs.imm_s     === mon_e.imm_s)
               && (!mon_e.mask[0] || obs.rt_imm_s  === mon_e.rt_imm_s);
         n_vec++;
         if (!mon_ok) begin
            n_err++;
            $display("FAIL %s trace @%0t: got st=%b strb=%b ill=%b pc_s=%b w_r_s=%b wr_data_s=%b alu=%b imm_s=%b rt_imm_s=%b; need st=%b strb=%b ill=%b pc_s=%b w_r_s=%b wr_data_s=%b alu=%b imm_s=%b rt_imm_s=%b (mask %b)",
                     cur_tag, $time, obs.st, obs.strb, obs.ill, obs.pc_s, obs.w_r_s, obs.wr_data_s, obs.alu,
                     obs.imm_s, obs.rt_imm_s, mon_e.st, mon_e.strb, mon_e.ill, mon_e.pc_s, mon_e.w_r_s,
                     mon_e.wr_data_s, mon_e.alu, mon_e.imm_s, mon_e.rt_imm_s, mon_e.mask);
         end
      end
   end

   function automatic exp_t blank(input logic [2:0] st);
      exp_t e;
      e      = '0;
      e.st   = st;
      e.mask = M_ILL;
      return e;
   endfunction

   // Expected per-cycle behaviour of one instruction, with an optional en=0 window inserted before record stall_at.
   task automatic push_trace(input logic [31:0] inst, input logic zf, input int lat,
                             input int stall_at, input int stall_len, output int len);
      exp_t t[$];
      exp_t e;
      int   kind;
      logic [5:0] op, fn;
      op = inst[31:26];
      fn = inst[5:0];
      for (int k = 0; k < lat; k++) begin
         e = blank(ST_IF);
         e.strb = S_MR;
         if (k == lat - 1) begin
            e.strb = S_MR | S_IRW | S_PCW;
            e.mask = M_ILL | M_PCS;
         end
         t.push_back(e);
      end
      t.push_back(blank(ST_ID));
      e = blank(ST_EX);
      kind = K_ILL;
      case (op)
         6'b000000: begin
            kind = K_ALU;
            case (fn)
               6'h20: e.alu = 3'b100;
               6'h22: e.alu = 3'b101;
               6'h24: e.alu = 3'b000;
               6'h25: e.alu = 3'b001;
               6'h26: e.alu = 3'b010;
               6'h27: e.alu = 3'b011;
               6'h2A: e.alu = 3'b110;
               default: kind = K_ILL;
            endcase
            e.mask = M_ILL | M_ALU | M_RTI | M_WRS | M_WDS;
         end
         6'b001000: begin kind = K_ALU; e.alu = 3'b100; e.imm_s = 1'b1; end
         6'b001100: begin kind = K_ALU; e.alu = 3'b000; end
         6'b001101: begin kind = K_ALU; e.alu = 3'b001; end
         6'b001110: begin kind = K_ALU; e.alu = 3'b010; end
         6'b001010: begin kind = K_ALU; e.alu = 3'b110; e.imm_s = 1'b1; end
         6'b100011, 6'b101011: begin
            kind = (op == 6'b100011) ? K_LW : K_SW;
            e.alu = 3'b100; e.imm_s = 1'b1; e.rt_imm_s = 1'b1;
            e.mask = M_ILL | M_ALU | M_IMM | M_RTI;
         end
         6'b000100, 6'b000101: begin
            kind = K_BR;
            e.alu = 3'b101; e.pc_s = 2'b10;
            e.mask = M_ILL | M_ALU | M_RTI | M_PCS;
            if ((op == 6'b000100) ? zf : !zf) e.strb = S_PCW;
         end
         6'b000010: begin kind = K_BR; e.pc_s = 2'b11; e.strb = S_PCW; e.mask = M_ILL | M_PCS; end
         6'b000011: kind = K_JAL;
         default:   kind = K_ILL;
      endcase
      if (kind == K_ALU && op != 6'b000000) begin
         e.rt_imm_s = 1'b1;
         e.w_r_s    = 2'b01;
         e.mask     = M_ILL | M_ALU | M_IMM | M_RTI | M_WRS | M_WDS;
      end
      if (kind == K_ILL) begin
         e = blank(ST_EX);
         e.mask = '0;
      end
      t.push_back(e);
      if (kind == K_LW || kind == K_SW) begin
         for (int k = 0; k < lat; k++) begin
            e = blank(ST_MEM);
            e.alu = 3'b100; e.imm_s = 1'b1; e.rt_imm_s = 1'b1;
            e.mask = M_ILL | M_ALU | M_IMM | M_RTI;
            if (kind == K_LW) e.strb = S_MR;
            else if (k == lat - 1) e.strb = S_MW;
            t.push_back(e);
         end
      end
      if (kind == K_ALU) begin
         e = blank(ST_WB);
         e.strb = S_WR;
         t.push_back(e);
      end else if (kind == K_LW) begin
         e = blank(ST_WB);
         e.strb = S_WR; e.w_r_s = 2'b01; e.wr_data_s = 2'b01;
         e.mask = M_ILL | M_WRS | M_WDS;
         t.push_back(e);
      end else if (kind == K_JAL) begin
         e = blank(ST_WB);
         e.strb = S_WR | S_PCW; e.w_r_s = 2'b10; e.wr_data_s = 2'b10; e.pc_s = 2'b11;
         e.mask = M_ILL | M_WRS | M_WDS | M_PCS;
         t.push_back(e);
      end
      len = 0;
      for (int i = 0; i < t.size(); i++) begin
         if (i == stall_at) begin
            for (int s = 0; s < stall_len; s++) begin
               e = t[i];
               e.strb = '0;
               sb.push_back(e);
               len++;
            end
         end
         sb.push_back(t[i]);
         len++;
      end
   endtask

   // Issue one instruction to the selected instance and run it to completion, then check where it lands.
   task automatic exec(input string tag, input logic [31:0] inst, input logic zf,
                       input int stall_at, input int stall_len, input logic [2:0] nxt);
      int len;
      cur_tag = tag;
      Inst_in = inst;
      ZF      = zf;
      push_trace(inst, zf, dsel ? 3 : 1, stall_at, stall_len, len);
      for (int c = 0; c < len; c++) begin
         en = !(stall_at >= 0 && c >= stall_at && c < stall_at + stall_len);
         @(posedge clk);
         #1;
      end
      en = 1'b1;
      n_vec++;
      if (obs.st !== nxt) begin
         n_err++;
         $display("FAIL %s end_state: got %b need %b", tag, obs.st, nxt);
      end
   endtask

   task automatic test_reset();
      cur_tag = "reset";
      Inst_in = 32'h014B4820;
      rst1 = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      n_vec++;
      if (obs.st !== ST_WB) begin n_err++; $display("FAIL reset pre_wb_state: got %b need %b", obs.st, ST_WB); end
      rst1 = 1'b1;
      @(negedge clk);
      n_vec++;
      if (obs.strb !== 5'b0) begin n_err++; $display("FAIL reset strobes_in_wb: got %b need 00000", obs.strb); end
      @(posedge clk); #1;
      @(negedge clk);
      n_vec++;
      if (obs.st !== ST_IF || obs.strb !== 5'b0 || obs.ill !== 1'b0 ||
          {obs.pc_s, obs.w_r_s, obs.wr_data_s, obs.alu, obs.imm_s, obs.rt_imm_s} !== 11'b0) begin
         n_err++;
         $display("FAIL reset held_outputs: got st=%b strb=%b ill=%b sel=%b need all zero",
                  obs.st, obs.strb, obs.ill, {obs.pc_s, obs.w_r_s, obs.wr_data_s, obs.alu, obs.imm_s, obs.rt_imm_s});
      end
      @(posedge clk); #1;
      rst1 = 1'b0;
      n_vec++;
      if (obs.st !== ST_IF || f_rs !== 5'd0 || f_rt !== 5'd0 || f_rd !== 5'd0 || f_ja !== 26'd0) begin
         n_err++;
         $display("FAIL reset after_release: got st=%b rs=%0d rt=%0d rd=%0d j_addr=%h need IF and IR=0",
                  obs.st, f_rs, f_rt, f_rd, f_ja);
      end
   endtask

   task automatic test_rtype();
      logic [31:0] r_tab [7];
      r_tab = '{32'h014B4820, 32'h014B4822, 32'h014B4824, 32'h014B4825,
                32'h014B4826, 32'h014B4827, 32'h014B482A};
      foreach (r_tab[i]) exec("rtype", r_tab[i], 1'b0, -1, 0, ST_IF);
      n_vec++;
      if (f_rs !== 5'd10 || f_rt !== 5'd11 || f_rd !== 5'd9) begin
         n_err++;
         $display("FAIL rtype fields: got rs=%0d rt=%0d rd=%0d need 10 11 9", f_rs, f_rt, f_rd);
      end
   endtask

   task automatic test_imm();
      logic [31:0] i_tab [5];
      i_tab = '{32'h2149FFFC, 32'h3149000F, 32'h3549000F, 32'h3949000F, 32'h2949FFFC};
      foreach (i_tab[i]) exec("imm", i_tab[i], 1'b0, -1, 0, ST_IF);
      n_vec++;
      if (f_imm !== 16'hFFFC || f_rt !== 5'd9) begin
         n_err++;
         $display("FAIL imm fields: got imm=%h rt=%0d need fffc 9", f_imm, f_rt);
      end
   endtask

   task automatic test_branch();
      exec("beq_taken",    32'h11090003, 1'b1, -1, 0, ST_IF);
      exec("beq_nottaken", 32'h11090003, 1'b0, -1, 0, ST_IF);
      exec("bne_taken",    32'h15090003, 1'b0, -1, 0, ST_IF);
      exec("bne_nottaken", 32'h15090003, 1'b1, -1, 0, ST_IF);
   endtask

   task automatic test_jump();
      exec("j", 32'h08000010, 1'b0, -1, 0, ST_IF);
      n_vec++;
      if (f_ja !== 26'h0000010) begin
         n_err++;
         $display("FAIL j j_addr: got %h need 0000010", f_ja);
      end
      exec("jal", 32'h0C000010, 1'b0, -1, 0, ST_IF);
   endtask

   task automatic test_mem_latency();
      exec("lw3", 32'h8D090004, 1'b0, -1, 0, ST_IF);
      n_vec++;
      if (f_imm !== 16'h0004 || f_rs !== 5'd8 || f_rt !== 5'd9) begin
         n_err++;
         $display("FAIL lw3 fields: got imm=%h rs=%0d rt=%0d need 0004 8 9", f_imm, f_rs, f_rt);
      end
      exec("sw3", 32'hAD090004, 1'b0, -1, 0, ST_IF);
   endtask

   task automatic test_stall();
      // record 6 is the second MEM cycle of lw at MEM_LAT=3
      exec("lw_stall", 32'h8D090004, 1'b0, 6, 5, ST_IF);
      exec("sw_stall", 32'hAD090004, 1'b0, 7, 5, ST_IF);
   endtask

   task automatic test_back_to_back();
      exec("b2b_add", 32'h014B4820, 1'b0, -1, 0, ST_IF);
      exec("b2b_lw",  32'h8D090004, 1'b0, -1, 0, ST_IF);
      exec("b2b_bne", 32'h15090003, 1'b0, -1, 0, ST_IF);
      exec("b2b_jal", 32'h0C000010, 1'b0, -1, 0, ST_IF);
   endtask

   task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
      exec("illegal", 32'hFC000000, 1'b0, -1, 0, ST_TRAP);
      cur_tag = "trap";
      Inst_in = 32'h014B4820;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_vec++;
         if (obs.st !== ST_TRAP || obs.ill !== 1'b1 || obs.strb !== 5'b0) begin
            n_err++;
            $display("FAIL trap hold: got st=%b ill=%b strb=%b need 101 1 00000", obs.st, obs.ill, obs.strb);
         end
         @(posedge clk); #1;
      end
      rst3 = 1'b1;
      @(posedge clk); #1;
      rst3 = 1'b0;
      n_vec++;
      if (obs.st !== ST_IF || obs.ill !== 1'b0) begin
         n_err++;
         $display("FAIL trap release: got st=%b ill=%b need 000 0", obs.st, obs.ill);
      end
`else
      exec("illegal", 32'hFC000000, 1'b0, -1, 0, ST_IF);
      n_vec++;
      if (obs.ill !== 1'b0) begin
         n_err++;
         $display("FAIL illegal flag: got %b need 0", obs.ill);
      end
`endif
      exec("after_illegal", 32'h014B4820, 1'b0, -1, 0, ST_IF);
   endtask

   initial begin
      rst1 = 1'b1; rst3 = 1'b1; en = 1'b1; ZF = 1'b0; dsel = 1'b0; Inst_in = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_rtype();
      test_imm();
      test_branch();
      test_jump();
      rst1 = 1'b1;
      rst3 = 1'b0;
      dsel = 1'b1;
      test_mem_latency();
      test_rtype();
      test_stall();
      test_back_to_back();
      test_illegal();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
